key_unroll: RTL and testbench

- Produces PRESENT-80 round keys in reverse order (K32 down to K1) for the decryption datapath.
- On load, expands the user key forward through 31 key-update steps to reach K32.
- Then steps backward one round key per Next request using the inverse key update.
- Sits between the key input register and the inverse round datapath, the counterpart of the forward per-round key update.

---
 rtl/key_unroll.sv | 108 ++++++++++
 tb/tb_key_unroll.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_unroll.sv
// PRESENT-80 reverse key schedule: expands the user key forward to K32 on load,
// then walks back one round key per Next_i request using the inverse key update.
module key_unroll (
  input  logic        Clk_ik,
  input  logic        Reset_ir,
  input  logic [79:0] Key_ib,
  input  logic        Load_i,
  input  logic        Next_i,
  output logic        Busy_o,
  output logic [63:0] RoundKey_ob,
  output logic        RoundKeyValid_o,
  output logic [5:0]  RoundIdx_ob,
  output logic        Done_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  state_t      state;
  logic [79:0] keyReg;
  logic [5:0]  cnt;

  function automatic logic [3:0] sBox(input logic [3:0] x);
    case (x)
      4'h0: sBox = 4'hC;  4'h1: sBox = 4'h5;  4'h2: sBox = 4'h6;  4'h3: sBox = 4'hB;
      4'h4: sBox = 4'h9;  4'h5: sBox = 4'h0;  4'h6: sBox = 4'hA;  4'h7: sBox = 4'hD;
      4'h8: sBox = 4'h3;  4'h9: sBox = 4'hE;  4'hA: sBox = 4'hF;  4'hB: sBox = 4'h8;
      4'hC: sBox = 4'h4;  4'hD: sBox = 4'h7;  4'hE: sBox = 4'h1;  default: sBox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sBoxInv(input logic [3:0] x);
    case (x)
      4'h0: sBoxInv = 4'h5;  4'h1: sBoxInv = 4'hE;  4'h2: sBoxInv = 4'hF;  4'h3: sBoxInv = 4'h8;
      4'h4: sBoxInv = 4'hC;  4'h5: sBoxInv = 4'h1;  4'h6: sBoxInv = 4'h2;  4'h7: sBoxInv = 4'hD;
      4'h8: sBoxInv = 4'hB;  4'h9: sBoxInv = 4'h4;  4'hA: sBoxInv = 4'h6;  4'hB: sBoxInv = 4'h3;
      4'hC: sBoxInv = 4'h0;  4'hD: sBoxInv = 4'h7;  4'hE: sBoxInv = 4'h9;  default: sBoxInv = 4'hA;
    endcase
  endfunction

  // NOTE: function locals are plain combinational temporaries, so blocking '=' is correct here.
  function automatic logic [79:0] fwdUpdate(input logic [79:0] k, input logic [5:0] c);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sBox(r[79:76]);
    r[19:15]   = r[19:15] ^ c[4:0];
    return r;
  endfunction

  // Undoes fwdUpdate step by step in reverse order.
  function automatic logic [79:0] invUpdate(input logic [79:0] k, input logic [5:0] c);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ c[4:0];
    r[79:76]   = sBoxInv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  // NOTE: every register is assigned with '<=' so all state updates see pre-edge values.
  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      state  <= IDLE;
      keyReg <= '0;
      cnt    <= '0;
      Done_o <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Load_i) begin
            keyReg <= Key_ib;
            cnt    <= 6'd1;
            state  <= EXPAND;
          end
        end
        EXPAND: begin
          keyReg <= fwdUpdate(keyReg, cnt);
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= READY;
        end
        READY: begin
          if (Next_i) begin
            if (cnt > 6'd1) begin
              keyReg <= invUpdate(keyReg, cnt - 6'd1);
              cnt    <= cnt - 6'd1;
            end else begin
              keyReg <= '0;
              cnt    <= '0;
              Done_o <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign Busy_o          = (state != IDLE);
  assign RoundKeyValid_o = (state == READY);
  assign RoundKey_ob     = RoundKeyValid_o ? keyReg[79:16] : 64'd0;
  assign RoundIdx_ob     = RoundKeyValid_o ? cnt : 6'd0;

endmodule

// File: tb/tb_key_unroll.sv
// Scoreboard bench for key_unroll: a forward key-schedule model queues K32..K1
// at each load and the monitor compares every valid cycle against the queue head.
module tb_key_unroll;

  logic        Clk_ik = 1'b0;
  logic        Reset_ir = 1'b1;
  logic [79:0] Key_ib = '0;
  logic        Load_i = 1'b0;
  logic        Next_i = 1'b0;
  logic        Busy_o;
  logic [63:0] RoundKey_ob;
  logic        RoundKeyValid_o;
  logic [5:0]  RoundIdx_ob;
  logic        Done_o;

  key_unroll dut (
    .Clk_ik(Clk_ik), .Reset_ir(Reset_ir), .Key_ib(Key_ib), .Load_i(Load_i), .Next_i(Next_i),
    .Busy_o(Busy_o), .RoundKey_ob(RoundKey_ob), .RoundKeyValid_o(RoundKeyValid_o),
    .RoundIdx_ob(RoundIdx_ob), .Done_o(Done_o)
  );

  always #5 Clk_ik = ~Clk_ik;

  typedef struct {
    logic [63:0] key;
    logic [5:0]  idx;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails = 0;
  int          doneCnt = 0;
  bit          zeroRun = 1'b0;
  logic [79:0] curKey = '0;
  logic [3:0]  sTab[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [79:0] randKey();
    logic [31:0] a, b, c;
    a = $urandom();
    b = $urandom();
    c = $urandom();
    return {a, b, c[15:0]};
  endfunction

  function automatic logic [79:0] refFwd(input logic [79:0] k, input int c);
    logic [79:0] r;
    logic [4:0]  c5;
    c5       = c[4:0];
    r        = (k << 61) | (k >> 19);
    r[79:76] = sTab[r[79:76]];
    r[19:15] = r[19:15] ^ c5;
    return r;
  endfunction

  task automatic pushExpected(input logic [79:0] key);
    logic [79:0] ks[33];
    ks[1] = key;
    for (int i = 1; i <= 31; i++) ks[i+1] = refFwd(ks[i], i);
    for (int i = 32; i >= 1; i--) sbq.push_back('{ks[i][79:16], 6'(i)});
  endtask

  // Every valid cycle must show the queue head; a cycle with Next_i high consumes it.
  always @(negedge Clk_ik) begin
    if (Done_o === 1'b1) doneCnt++;
    if (RoundKeyValid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpectedValid", 80'(RoundIdx_ob), 80'd0);
      end else begin
        check("roundKey", 80'(RoundKey_ob), 80'(sbq[0].key));
        check("roundIdx", 80'(RoundIdx_ob), 80'(sbq[0].idx));
        if (zeroRun && RoundIdx_ob == 6'd2)
          check("k2ZeroKey", 80'(RoundKey_ob), 80'h0000_C000_0000_0000_0000);
        if (RoundIdx_ob == 6'd1) check("k1IsUserKey", 80'(RoundKey_ob), 80'(curKey[79:16]));
        if (Next_i) void'(sbq.pop_front());
      end
    end else if (RoundKeyValid_o === 1'b0) begin
      check("zeroWhenInvalid", 80'({RoundKey_ob, RoundIdx_ob}), 80'd0);
    end
  end

  // Load cycle counts as cycle 1, so valid must appear after the 32nd edge.
  task automatic doLoad(input logic [79:0] key, input bit noisy);
    int n;
    curKey = key;
    pushExpected(key);
    Key_ib = key;
    Load_i = 1'b1;
    Next_i = 1'b0;
    @(posedge Clk_ik); #1;
    n = 1;
    check("busyAfterLoad", 80'(Busy_o), 80'd1);
    Load_i = 1'b0;
    while (RoundKeyValid_o !== 1'b1 && n < 40) begin
      if (noisy) begin
        Next_i = 1'($urandom_range(0, 1));
        Load_i = 1'($urandom_range(0, 1));
        Key_ib = randKey();
      end
      @(posedge Clk_ik); #1;
      n++;
    end
    Next_i = 1'b0;
    Load_i = 1'b0;
    check("validLatency", 80'(n), 80'd32);
    check("firstIdx", 80'(RoundIdx_ob), 80'd32);
  endtask

  task automatic drain(input int maxGap, input bit noisy);
    int gap;
    for (int i = 0; i < 32; i++) begin
      gap = (maxGap == 0) ? 0 : $urandom_range(0, maxGap);
      repeat (gap) begin
        Next_i = 1'b0;
        if (noisy) begin Load_i = 1'($urandom_range(0, 1)); Key_ib = randKey(); end
        @(posedge Clk_ik); #1;
      end
      Next_i = 1'b1;
      if (noisy) begin Load_i = 1'($urandom_range(0, 1)); Key_ib = randKey(); end
      @(posedge Clk_ik); #1;
    end
    Next_i = 1'b0;
    Load_i = 1'b0;
    check("doneAfterK1", 80'(Done_o), 80'd1);
    check("idleAfterK1", 80'(Busy_o), 80'd0);
    check("sbDrained", 80'(sbq.size()), 80'd0);
  endtask

  initial begin
    int savedDone;
    repeat (2) @(posedge Clk_ik);
    #1;
    check("resetOutputs", {RoundKey_ob, RoundIdx_ob, Busy_o, RoundKeyValid_o, Done_o}, 80'd0);
    Reset_ir = 1'b0;

    // Next_i in IDLE does nothing.
    Next_i = 1'b1;
    repeat (3) begin @(posedge Clk_ik); #1; end
    Next_i = 1'b0;
    check("idleIgnoresNext", 80'({Busy_o, RoundKeyValid_o, Done_o}), 80'd0);

    // All-zero key, back-to-back Next_i.
    zeroRun = 1'b1;
    doLoad(80'd0, 1'b0);
    drain(0, 1'b0);
    zeroRun = 1'b0;
    @(posedge Clk_ik); #1;
    check("donePulseCount", 80'(doneCnt), 80'd1);
    check("doneIsPulse", 80'(Done_o), 80'd0);

    // Random keys; each reload lands in the Done_o cycle of the previous run.
    doLoad(randKey(), 1'b1);
    for (int n = 0; n < 100; n++) begin
      drain((n < 50) ? 0 : 5, 1'b1);
      if (n < 99) doLoad(randKey(), 1'b1);
    end
    @(posedge Clk_ik); #1;
    check("idleAfterRandom", 80'({Busy_o, RoundKeyValid_o}), 80'd0);

    // Reset while showing K17.
    doLoad(randKey(), 1'b0);
    repeat (15) begin
      Next_i = 1'b1;
      @(posedge Clk_ik); #1;
    end
    Next_i = 1'b0;
    check("idxBeforeReset", 80'(RoundIdx_ob), 80'd17);
    savedDone = doneCnt;
    Reset_ir = 1'b1;
    @(posedge Clk_ik); #1;
    sbq.delete();
    check("midResetOutputs", {RoundKey_ob, RoundIdx_ob, Busy_o, RoundKeyValid_o, Done_o}, 80'd0);
    Reset_ir = 1'b0;
    @(posedge Clk_ik); #1;
    check("noDoneOnReset", 80'(doneCnt - savedDone), 80'd0);

    doLoad(randKey(), 1'b0);
    drain(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
